// File: rtl/gr_wb_sched_pkg.sv
// Shared definitions for the general-register writeback scheduler.
package gr_wb_sched_pkg;
  localparam int GR_ADDR_W = 5;
  localparam int GR_DATA_W = 32;
  localparam int GR_NUM    = 32;

  typedef logic [GR_ADDR_W-1:0] gr_addr_t;
  typedef logic [GR_DATA_W-1:0] gr_data_t;

  localparam gr_addr_t GR_ZERO = '0;

  // One buffered long-unit result.
  typedef struct packed {
    gr_addr_t addr;
    gr_data_t data;
  } gr_wr_t;

  // x0 is hard-wired, so writes to it are dropped and it is never tracked.
  function automatic logic is_zero(input gr_addr_t a);
    return a == GR_ZERO;
  endfunction
endpackage

// File: rtl/gr_wb_sched_if.sv
// Issue, writeback, long-unit and gr write-port signals of the scheduler.
interface gr_wb_sched_if;
  import gr_wb_sched_pkg::*;

  logic     iss_valid;
  logic     iss_long;
  gr_addr_t iss_rd;
  gr_addr_t iss_rs1;
  gr_addr_t iss_rs2;
  gr_addr_t iss_rs3;
  logic     iss_ready;

  logic     pipe_wb_valid;
  gr_addr_t pipe_wb_addr;
  gr_data_t pipe_wb_data;
  logic     pipe_hold;

  logic     lu_valid;
  gr_addr_t lu_addr;
  gr_data_t lu_data;
  logic     lu_ready;

  logic     gr_we;
  gr_addr_t gr_waddr;
  gr_data_t gr_wdata;

  modport slave (
    input  iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2, iss_rs3,
    input  pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
    input  lu_valid, lu_addr, lu_data,
    output iss_ready, pipe_hold, lu_ready, gr_we, gr_waddr, gr_wdata
  );

  modport master (
    output iss_valid, iss_long, iss_rd, iss_rs1, iss_rs2, iss_rs3,
    output pipe_wb_valid, pipe_wb_addr, pipe_wb_data,
    output lu_valid, lu_addr, lu_data,
    input  iss_ready, pipe_hold, lu_ready, gr_we, gr_waddr, gr_wdata
  );
endinterface

// File: rtl/gr_wb_sched_scoreboard.sv
// Pending-destination scoreboard for long-latency ops plus the issue hazard check.
module gr_wb_sched_scoreboard
  import gr_wb_sched_pkg::*;
#(
  parameter int MAX_OUT = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     iss_valid,
  input  logic     iss_long,
  input  gr_addr_t iss_rd,
  input  gr_addr_t iss_rs1,
  input  gr_addr_t iss_rs2,
  input  gr_addr_t iss_rs3,
  input  logic     clr_valid,
  input  gr_addr_t clr_addr,
  output logic     iss_ready
);
  localparam int CNT_W = $clog2(GR_NUM + 1);

  logic [GR_NUM-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              set, clr;

  // A bit being cleared this cycle still blocks; the op issues next cycle.
  assign iss_ready = !pend_q[iss_rs1] && !pend_q[iss_rs2] && !pend_q[iss_rs3] &&
                     !pend_q[iss_rd] && !(iss_long && cnt_q == CNT_W'(MAX_OUT));

  // Next pending set and outstanding count from issue and buffered writeback.
  always_comb begin
    set    = iss_valid && iss_ready && iss_long && !is_zero(iss_rd);
    clr    = clr_valid && pend_q[clr_addr];
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (clr) pend_d[clr_addr] = 1'b0;
    if (set) pend_d[iss_rd] = 1'b1;
    pend_d[0] = 1'b0;
    case ({set, clr})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/gr_wb_sched.sv
// Merges pipeline writeback and buffered long-unit results onto the single
// gr write port, with a starvation hold on the pipeline.
module gr_wb_sched
  import gr_wb_sched_pkg::*;
#(
  parameter int MAX_OUT    = 4,
  parameter int STARVE_MAX = 8
) (
  input logic          clk,
  input logic          rst_n,
  gr_wb_sched_if.slave bus
);
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_MAX - 1);

  logic              buf_full_q, buf_full_d;
  gr_wr_t            buf_q, buf_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              hold_q, hold_d;
  logic              we_q, we_d;
  gr_addr_t          waddr_q, waddr_d;
  gr_data_t          wdata_q, wdata_d;
  logic              src_buf_q, src_buf_d;
  logic              fill, drain;

  assign fill  = bus.lu_valid && !buf_full_q;
  assign drain = !bus.pipe_wb_valid && buf_full_q;

  // Holding buffer: captures a long result, empties when it wins the port.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    if (drain) begin
      buf_full_d = 1'b0;
    end else if (fill) begin
      buf_full_d = 1'b1;
      buf_d      = '{addr: bus.lu_addr, data: bus.lu_data};
    end
  end

  // Write-port select: pipeline first, then buffer; x0 writes suppressed.
  always_comb begin
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    src_buf_d = 1'b0;
    if (bus.pipe_wb_valid) begin
      we_d    = !is_zero(bus.pipe_wb_addr);
      waddr_d = bus.pipe_wb_addr;
      wdata_d = bus.pipe_wb_data;
    end else if (buf_full_q) begin
      we_d      = !is_zero(buf_q.addr);
      waddr_d   = buf_q.addr;
      wdata_d   = buf_q.data;
      src_buf_d = 1'b1;
    end
  end

  // Starvation: count blocked cycles, hold the pipe until one cycle after drain.
  always_comb begin
    wait_d = wait_q;
    hold_d = hold_q;
    if (!buf_full_q || drain) wait_d = '0;
    else if (wait_q != WAIT_LAST) wait_d = wait_q + 1'b1;
    if (buf_full_q && !drain && wait_q == WAIT_LAST) hold_d = 1'b1;
    if (src_buf_q) hold_d = 1'b0;
  end

  // Control and write-port registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full_q <= 1'b0;
      wait_q     <= '0;
      hold_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      src_buf_q  <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      wait_q     <= wait_d;
      hold_q     <= hold_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      src_buf_q  <= src_buf_d;
    end
  end

  // Buffer payload; only meaningful while buf_full_q is set.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  gr_wb_sched_scoreboard #(.MAX_OUT(MAX_OUT)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (bus.iss_valid),
    .iss_long  (bus.iss_long),
    .iss_rd    (bus.iss_rd),
    .iss_rs1   (bus.iss_rs1),
    .iss_rs2   (bus.iss_rs2),
    .iss_rs3   (bus.iss_rs3),
    .clr_valid (we_q && src_buf_q),
    .clr_addr  (waddr_q),
    .iss_ready (bus.iss_ready)
  );

  assign bus.lu_ready  = !buf_full_q;
  assign bus.pipe_hold = hold_q;
  assign bus.gr_we     = we_q;
  assign bus.gr_waddr  = waddr_q;
  assign bus.gr_wdata  = wdata_q;
endmodule

// File: tb/tb_gr_wb_sched.sv
// Testbench for gr_wb_sched: directed scenarios plus a randomized run against
// a queue-based reference model.
module tb_gr_wb_sched;
  import gr_wb_sched_pkg::*;

  localparam int MAX_OUT    = 4;
  localparam int STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  gr_wb_sched_if bus();

  gr_wb_sched #(.MAX_OUT(MAX_OUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int       pq[$];        // registers with a long result outstanding
  int       lu_todo[$];   // long results the long unit still owes
  bit       mb_full;
  gr_addr_t mb_addr;
  gr_data_t mb_data;
  int       age;          // cycles the buffered result has been blocked
  bit       e_hold, e_we, e_from_buf, drained_prev;
  gr_addr_t e_waddr;
  gr_data_t e_wdata;
  bit       obs_ready, exp_ready;

  function automatic bit in_pend(int r);
    foreach (pq[i]) if (pq[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void pend_drop(int r);
    for (int i = 0; i < pq.size(); i++) if (pq[i] == r) begin pq.delete(i); return; end
  endfunction

  function automatic void todo_drop(int r);
    for (int i = 0; i < lu_todo.size(); i++) if (lu_todo[i] == r) begin lu_todo.delete(i); return; end
  endfunction

  function automatic bit m_ready();
    if (in_pend(int'(bus.iss_rs1)) || in_pend(int'(bus.iss_rs2)) ||
        in_pend(int'(bus.iss_rs3)) || in_pend(int'(bus.iss_rd))) return 1'b0;
    if (bus.iss_long && pq.size() == MAX_OUT) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    bit fire, drain, nh;
    if (!rst_n) begin
      pq.delete(); lu_todo.delete();
      mb_full = 0; age = 0; e_hold = 0; e_we = 0; e_from_buf = 0; drained_prev = 0;
      e_waddr = '0; e_wdata = '0;
      return;
    end
    fire = bus.iss_valid && exp_ready && bus.iss_long && bus.iss_rd != 0;
    if (e_we && e_from_buf) pend_drop(int'(e_waddr));
    if (fire) begin pq.push_back(int'(bus.iss_rd)); lu_todo.push_back(int'(bus.iss_rd)); end
    drain = !bus.pipe_wb_valid && mb_full;
    nh = e_hold;
    if (mb_full && !drain && age >= STARVE_MAX - 1) nh = 1;
    if (drained_prev) nh = 0;
    e_hold = nh;
    drained_prev = drain;
    if (bus.pipe_wb_valid) begin
      e_we = bus.pipe_wb_addr != 0; e_waddr = bus.pipe_wb_addr; e_wdata = bus.pipe_wb_data; e_from_buf = 0;
    end else if (mb_full) begin
      e_we = mb_addr != 0; e_waddr = mb_addr; e_wdata = mb_data; e_from_buf = 1;
    end else begin
      e_we = 0; e_from_buf = 0;
    end
    age = (mb_full && !drain) ? age + 1 : 0;
    if (drain) mb_full = 0;
    else if (bus.lu_valid && !mb_full) begin mb_full = 1; mb_addr = bus.lu_addr; mb_data = bus.lu_data; end
  endtask

  // One clock: sample combinational ready mid-cycle, advance model, settle after edge.
  task automatic cyc();
    @(negedge clk);
    obs_ready = bus.iss_ready;
    exp_ready = m_ready();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_valid = 0; bus.iss_long = 0; bus.iss_rd = 0;
    bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_rs3 = 0;
    bus.pipe_wb_valid = 0; bus.pipe_wb_addr = 0; bus.pipe_wb_data = 0;
    bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0;
  endtask

  // The pipeline must never present a writeback while held.
  always @(posedge clk) begin
    assert (!(rst_n && bus.pipe_hold === 1'b1 && bus.pipe_wb_valid === 1'b1))
    else begin errors++; $display("FAIL protocol: pipe_wb_valid while pipe_hold"); end
  end

  task automatic test_reset();
    idle(); rst_n = 0;
    bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 5;
    cyc(); cyc();
    checks++; if (bus.gr_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", bus.gr_we); end
    checks++; if (bus.gr_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", bus.gr_waddr); end
    checks++; if (bus.gr_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", bus.gr_wdata); end
    checks++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL reset_hold: got %b want 0", bus.pipe_hold); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready: got %b want 1", bus.lu_ready); end
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready: got %b want 1", obs_ready); end
    idle(); rst_n = 1;
    cyc();
  endtask

  task automatic test_raw();
    idle(); bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 5;
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL raw_issue: got %b want 1", obs_ready); end
    bus.iss_long = 0; bus.iss_rd = 9; bus.iss_rs1 = 5;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL raw_block%0d: got %b want 0", i, obs_ready); end
    end
    bus.lu_valid = 1; bus.lu_addr = 5; bus.lu_data = 32'hDEADBEEF; todo_drop(5);
    cyc();
    bus.lu_valid = 0;
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL raw_t0: got %b want 0", obs_ready); end
    cyc();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL raw_t1: got %b want 0", obs_ready); end
    checks++; if (bus.gr_we !== 1'b1 || bus.gr_waddr !== 5'd5 || bus.gr_wdata !== 32'hDEADBEEF)
      begin errors++; $display("FAIL raw_write: got we=%b addr=%0d data=%h want 1/5/deadbeef", bus.gr_we, bus.gr_waddr, bus.gr_wdata); end
    cyc();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL raw_t2: got %b want 0", obs_ready); end
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL raw_t3: got %b want 1", obs_ready); end
    idle(); cyc();
  endtask

  task automatic test_collision();
    idle();
    bus.pipe_wb_valid = 1; bus.pipe_wb_addr = 3; bus.pipe_wb_data = 32'h11;
    bus.lu_valid = 1; bus.lu_addr = 7; bus.lu_data = 32'h22;
    cyc();
    idle();
    checks++; if (bus.gr_we !== 1'b1 || bus.gr_waddr !== 5'd3 || bus.gr_wdata !== 32'h11)
      begin errors++; $display("FAIL coll_pipe: got we=%b addr=%0d data=%h want 1/3/11", bus.gr_we, bus.gr_waddr, bus.gr_wdata); end
    checks++; if (bus.lu_ready !== 1'b0) begin errors++; $display("FAIL coll_lu_ready: got %b want 0", bus.lu_ready); end
    cyc();
    checks++; if (bus.gr_we !== 1'b1 || bus.gr_waddr !== 5'd7 || bus.gr_wdata !== 32'h22)
      begin errors++; $display("FAIL coll_buf: got we=%b addr=%0d data=%h want 1/7/22", bus.gr_we, bus.gr_waddr, bus.gr_wdata); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL coll_lu_ready2: got %b want 1", bus.lu_ready); end
    cyc();
    checks++; if (bus.gr_we !== 1'b0) begin errors++; $display("FAIL coll_idle: got %b want 0", bus.gr_we); end
  endtask

  task automatic test_starve();
    idle();
    bus.pipe_wb_valid = 1; bus.pipe_wb_addr = 10; bus.pipe_wb_data = 32'h100;
    bus.lu_valid = 1; bus.lu_addr = 8; bus.lu_data = 32'hA5A50008;
    cyc();
    bus.lu_valid = 0;
    for (int i = 1; i <= STARVE_MAX; i++) begin
      bus.pipe_wb_data = 32'h100 + i;
      cyc();
      checks++; if (bus.pipe_hold !== (i == STARVE_MAX)) begin errors++;
        $display("FAIL starve_hold%0d: got %b want %b", i, bus.pipe_hold, i == STARVE_MAX); end
    end
    bus.pipe_wb_valid = 0;
    cyc();
    checks++; if (bus.gr_we !== 1'b1 || bus.gr_waddr !== 5'd8 || bus.gr_wdata !== 32'hA5A50008)
      begin errors++; $display("FAIL starve_drain: got we=%b addr=%0d data=%h want 1/8/a5a50008", bus.gr_we, bus.gr_waddr, bus.gr_wdata); end
    checks++; if (bus.pipe_hold !== 1'b1) begin errors++; $display("FAIL starve_hold_drain: got %b want 1", bus.pipe_hold); end
    cyc();
    checks++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL starve_release: got %b want 0", bus.pipe_hold); end
  endtask

  task automatic test_zero();
    idle(); bus.pipe_wb_valid = 1; bus.pipe_wb_addr = 0; bus.pipe_wb_data = 32'hFFFFFFFF;
    cyc();
    checks++; if (bus.gr_we !== 1'b0) begin errors++; $display("FAIL zero_pipe_we: got %b want 0", bus.gr_we); end
    idle(); bus.lu_valid = 1; bus.lu_addr = 0; bus.lu_data = 32'h77;
    cyc();
    idle();
    cyc();
    checks++; if (bus.gr_we !== 1'b0) begin errors++; $display("FAIL zero_buf_we: got %b want 0", bus.gr_we); end
    checks++; if (bus.lu_ready !== 1'b1) begin errors++; $display("FAIL zero_buf_drained: got %b want 1", bus.lu_ready); end
    bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 0;
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL zero_issue: got %b want 1", obs_ready); end
    idle(); cyc();
  endtask

  task automatic test_max_out();
    idle();
    for (int r = 1; r <= 4; r++) begin
      bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 5'(r);
      cyc();
      checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL max_issue%0d: got %b want 1", r, obs_ready); end
    end
    bus.iss_rd = 6;
    cyc();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL max_long_blocked: got %b want 0", obs_ready); end
    bus.iss_long = 0;
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL max_short_ok: got %b want 1", obs_ready); end
    idle();
    for (int r = 1; r <= 4; r++) begin
      bus.lu_valid = 1; bus.lu_addr = 5'(r); bus.lu_data = 32'h101 * r; todo_drop(r);
      cyc();
      bus.lu_valid = 0;
      cyc();
    end
    cyc();
    bus.iss_long = 1; bus.iss_rs1 = 1; bus.iss_rs2 = 2; bus.iss_rs3 = 3; bus.iss_rd = 4;
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL max_cleared: got %b want 1", obs_ready); end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    for (int r = 11; r <= 12; r++) begin
      bus.iss_valid = 1; bus.iss_long = 1; bus.iss_rd = 5'(r);
      cyc();
    end
    idle(); bus.lu_valid = 1; bus.lu_addr = 11; bus.lu_data = 32'hBEEF0011;
    cyc();
    idle(); rst_n = 0;
    bus.pipe_wb_valid = 1; bus.pipe_wb_addr = 20; bus.pipe_wb_data = 32'h1234;
    cyc();
    checks++; if (bus.gr_we !== 1'b0 || bus.gr_waddr !== 5'd0 || bus.gr_wdata !== 32'd0)
      begin errors++; $display("FAIL rmid_port: got we=%b addr=%0d data=%h want 0/0/0", bus.gr_we, bus.gr_waddr, bus.gr_wdata); end
    checks++; if (bus.pipe_hold !== 1'b0 || bus.lu_ready !== 1'b1)
      begin errors++; $display("FAIL rmid_ctrl: got hold=%b lu_ready=%b want 0/1", bus.pipe_hold, bus.lu_ready); end
    idle(); rst_n = 1;
    bus.iss_long = 1; bus.iss_rs1 = 11; bus.iss_rs2 = 12; bus.iss_rd = 13;
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL rmid_iss_ready: got %b want 1", obs_ready); end
    idle(); cyc();
  endtask

  task automatic test_random();
    int idx, budget;
    for (int i = 0; i < 600; i++) begin
      idle();
      bus.iss_valid = 1'($urandom_range(0, 1));
      bus.iss_long  = ($urandom_range(0, 2) == 0);
      bus.iss_rd    = 5'($urandom_range(0, 7));
      bus.iss_rs1   = 5'($urandom_range(0, 7));
      bus.iss_rs2   = 5'($urandom_range(0, 7));
      bus.iss_rs3   = 5'($urandom_range(0, 7));
      if (!e_hold && $urandom_range(0, 99) < ((i % 100) < 50 ? 30 : 90)) begin
        bus.pipe_wb_valid = 1; bus.pipe_wb_addr = 5'($urandom_range(0, 31)); bus.pipe_wb_data = $urandom;
      end
      if (!mb_full && lu_todo.size() > 0 && $urandom_range(0, 1) == 1) begin
        idx = $urandom_range(0, lu_todo.size() - 1);
        bus.lu_valid = 1; bus.lu_addr = 5'(lu_todo[idx]); bus.lu_data = $urandom;
        lu_todo.delete(idx);
      end
      cyc();
      checks++; if (obs_ready !== exp_ready) begin errors++; $display("FAIL rnd_iss_ready@%0d: got %b want %b", i, obs_ready, exp_ready); end
      checks++; if (bus.gr_we !== e_we) begin errors++; $display("FAIL rnd_we@%0d: got %b want %b", i, bus.gr_we, e_we); end
      if (e_we) begin
        checks++; if (bus.gr_waddr !== e_waddr || bus.gr_wdata !== e_wdata) begin errors++;
          $display("FAIL rnd_write@%0d: got %0d/%h want %0d/%h", i, bus.gr_waddr, bus.gr_wdata, e_waddr, e_wdata); end
      end
      checks++; if (bus.pipe_hold !== e_hold) begin errors++; $display("FAIL rnd_hold@%0d: got %b want %b", i, bus.pipe_hold, e_hold); end
      checks++; if (bus.lu_ready !== !mb_full) begin errors++; $display("FAIL rnd_lu_ready@%0d: got %b want %b", i, bus.lu_ready, !mb_full); end
    end
    budget = 0;
    while ((lu_todo.size() > 0 || mb_full || pq.size() > 0) && budget < 200) begin
      idle();
      if (!mb_full && lu_todo.size() > 0) begin
        bus.lu_valid = 1; bus.lu_addr = 5'(lu_todo[0]); bus.lu_data = $urandom; lu_todo.delete(0);
      end
      cyc();
      budget++;
    end
    checks++; if (budget >= 200) begin errors++; $display("FAIL rnd_flush: budget %0d exhausted, pending %0d", budget, pq.size()); end
    idle(); bus.iss_long = 1; bus.iss_rs1 = 1; bus.iss_rs2 = 2; bus.iss_rs3 = 3; bus.iss_rd = 4;
    cyc();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL rnd_final_ready: got %b want 1", obs_ready); end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    test_reset();
    test_raw();
    test_collision();
    test_starve();
    test_zero();
    test_max_out();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
